divider_master: RTL and testbench

Sequential radix-2 non-restoring integer divider; the inverse counterpart of the team's Booth multiplier master.
- Uses the same op_start/op_clear/state handshake and state encoding as the multiplier master, so one controller can drive both.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit.

---
 rtl/divider_master.sv | 173 +++++++++++++++++
 tb/tb_divider_master.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_master.sv
// -----------------------------------------------------------------------------
// divider_master
// Sequential radix-2 non-restoring integer divider producing one quotient bit
// per clock. It shares the op_start/op_clear/state handshake and the state
// encoding of the Booth multiplier master, so a single controller drives both.
//
// Build option: define DIVIDER_SIGNED_EN for two's-complement signed operands
// and results. Leave it undefined for an unsigned-only divider.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   op_start     start request, honoured only in IDLE
//   op_clear     abort / acknowledge, returns to IDLE (highest priority)
//   dividend     numerator, held stable from the request through START
//   divisor      denominator, same stability rule as dividend
//   quotient     result quotient, valid only in DONE, otherwise 0
//   remainder    result remainder, valid only in DONE, otherwise 0
//   div_by_zero  divisor was zero for the current result, valid only in DONE
//   state        IDLE=00, DONE=01, START=10, EXEC=11
// -----------------------------------------------------------------------------
module divider_master #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DONE  = 2'b01,
        START = 2'b10,
        EXEC  = 2'b11
    } state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic signed [WIDTH:0]   prem_q;     // partial remainder, one extra bit for sign
    logic [WIDTH-1:0]        qsr_q;      // dividend magnitude shifting out, quotient in
    logic [WIDTH-1:0]        dvs_q;      // divisor magnitude
    logic                    sgn_a_q;
    logic                    sgn_b_q;
    logic                    dbz_q;
    logic [WIDTH-1:0]        quot_q;
    logic [WIDTH-1:0]        rem_q;
    logic                    dbz_out_q;

    // Operand magnitudes and signs captured in START
    logic                    sgn_a_d;
    logic                    sgn_b_d;
    logic [WIDTH-1:0]        mag_a_d;
    logic [WIDTH-1:0]        mag_b_d;

    always_comb begin
`ifdef DIVIDER_SIGNED_EN
        sgn_a_d = dividend[WIDTH-1];
        sgn_b_d = divisor[WIDTH-1];
        // The most-negative value maps onto itself, which is the correct
        // unsigned magnitude 2^(WIDTH-1).
        mag_a_d = sgn_a_d ? -dividend : dividend;
        mag_b_d = sgn_b_d ? -divisor  : divisor;
`else
        sgn_a_d = 1'b0;
        sgn_b_d = 1'b0;
        mag_a_d = dividend;
        mag_b_d = divisor;
`endif
    end

    // One non-restoring iteration plus the final correction for the last one
    logic signed [WIDTH:0]   shifted_d;
    logic signed [WIDTH:0]   dvs_ext_d;
    logic signed [WIDTH:0]   prem_d;
    logic [WIDTH-1:0]        qsr_d;
    logic [WIDTH-1:0]        rem_mag_d;
    logic [WIDTH-1:0]        quot_d;
    logic [WIDTH-1:0]        rem_d;

    always_comb begin
        shifted_d = {prem_q[WIDTH-1:0], qsr_q[WIDTH-1]};
        dvs_ext_d = {1'b0, dvs_q};
        // The sign of the old remainder picks subtract or add; the shifted
        // value may wrap, but the sum always lands back in [-D, D).
        prem_d    = prem_q[WIDTH] ? (shifted_d + dvs_ext_d) : (shifted_d - dvs_ext_d);
        qsr_d     = {qsr_q[WIDTH-2:0], ~prem_d[WIDTH]};
        // Restoring a negative final remainder; the result fits in WIDTH bits.
        rem_mag_d = prem_d[WIDTH] ? (prem_d[WIDTH-1:0] + dvs_q) : prem_d[WIDTH-1:0];
        // With a zero divisor the iterations yield all ones and |dividend|;
        // forcing all ones keeps the quotient independent of operand signs.
        if (dbz_q) begin
            quot_d = '1;
        end else if (sgn_a_q ^ sgn_b_q) begin
            quot_d = -qsr_d;
        end else begin
            quot_d = qsr_d;
        end
        rem_d = sgn_a_q ? -rem_mag_d : rem_mag_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prem_q    <= '0;
            qsr_q     <= '0;
            dvs_q     <= '0;
            sgn_a_q   <= 1'b0;
            sgn_b_q   <= 1'b0;
            dbz_q     <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_out_q <= 1'b0;
        end else if (op_clear) begin
            state_q   <= IDLE;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_start) begin
                        state_q <= START;
                    end
                end
                START: begin
                    qsr_q   <= mag_a_d;
                    dvs_q   <= mag_b_d;
                    sgn_a_q <= sgn_a_d;
                    sgn_b_q <= sgn_b_d;
                    dbz_q   <= (divisor == '0);
                    prem_q  <= '0;
                    cnt_q   <= '0;
                    state_q <= EXEC;
                end
                EXEC: begin
                    prem_q <= prem_d;
                    qsr_q  <= qsr_d;
                    if (cnt_q == LAST) begin
                        state_q   <= DONE;
                        quot_q    <= quot_d;
                        rem_q     <= rem_d;
                        dbz_out_q <= dbz_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_out_q;
    assign state       = state_q;

endmodule

// File: tb/tb_divider_master.sv
module tb_divider_master;

    localparam int W = 64;
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_DONE  = 2'b01;
    localparam logic [1:0] S_START = 2'b10;
    localparam logic [1:0] S_EXEC  = 2'b11;

    localparam logic [W-1:0] MN   = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         op_start = 1'b0;
    logic         op_clear = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   state;

    int checks = 0;
    int errs   = 0;

    divider_master #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op_start    (op_start),
        .op_clear    (op_clear),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input string n, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        vec_t v;
        v.name = n; v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: division defined by truncation toward zero plus the two
    // special cases (zero divisor, signed overflow).
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        dz = 1'b0;
        if (b == '0) begin
            q  = ONES;
            r  = a;
            dz = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            if (a == MN && b == ONES) begin
                q = MN;
                r = '0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
    endtask

    // Drive a request; returns in START (one cycle after the sampling edge).
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 1;
        while (state != S_DONE && edges < 300) begin
            tick();
            edges++;
        end
    endtask

    task automatic clear_and_check(input string nm);
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
        chk({nm, " idle state"}, W'(state), W'(S_IDLE));
        chk({nm, " idle quotient"}, quotient, '0);
        chk({nm, " idle remainder"}, remainder, '0);
        chk({nm, " idle dbz"}, W'(div_by_zero), '0);
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int edges;
        start_op(a, b);
        chk({nm, " start state"}, W'(state), W'(S_START));
        chk({nm, " start quotient"}, quotient, '0);
        wait_done(edges);
        chk({nm, " latency"}, W'(edges), W'(W + 2));
        chk({nm, " quotient"}, quotient, eq);
        chk({nm, " remainder"}, remainder, er);
        chk({nm, " dbz"}, W'(div_by_zero), W'(edz));
        repeat (3) tick();
        chk({nm, " held state"}, W'(state), W'(S_DONE));
        chk({nm, " held quotient"}, quotient, eq);
        clear_and_check(nm);
    endtask

    initial begin
        logic [W-1:0] ra, rb, mq, mr;
        logic         mdz;
        int           edges;
        int           bad;

        // Reset state
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("reset state", W'(state), W'(S_IDLE));
        chk("reset quotient", quotient, '0);
        chk("reset remainder", remainder, '0);
        chk("reset dbz", W'(div_by_zero), '0);

        // Directed vectors
        add_vec("100/7",   100, 7, 14, 2, 1'b0);
        add_vec("12345/0", 12345, 0, ONES, 12345, 1'b1);
        add_vec("50/5",    50, 5, 10, 0, 1'b0);
        add_vec("0/9",     0, 9, 0, 0, 1'b0);
        add_vec("7/100",   7, 100, 0, 7, 1'b0);
        add_vec("1/1",     1, 1, 1, 0, 1'b0);
        add_vec("MN/1",    MN, 1, MN, 0, 1'b0);
`ifdef DIVIDER_SIGNED_EN
        add_vec("-100/7",  W'(-100), 7, W'(-14), W'(-2), 1'b0);
        add_vec("100/-7",  100, W'(-7), W'(-14), 2, 1'b0);
        add_vec("-100/-7", W'(-100), W'(-7), 14, W'(-2), 1'b0);
        add_vec("MN/-1",   MN, ONES, MN, 0, 1'b0);
        add_vec("-12345/0", W'(-12345), 0, ONES, W'(-12345), 1'b1);
        add_vec("MN/MN",   MN, MN, 1, 0, 1'b0);
`else
        add_vec("ones/1",    ONES, 1, ONES, 0, 1'b0);
        add_vec("MN/ones",   MN, ONES, 0, MN, 1'b0);
        add_vec("ones/ones", ONES, ONES, 1, 0, 1'b0);
        add_vec("ones/2",    ONES, 2, {1'b0, {(W-1){1'b1}}}, 1, 1'b0);
        add_vec("ones/MN",   ONES, MN, 1, {1'b0, {(W-1){1'b1}}}, 1'b0);
`endif
        foreach (tbl[i]) begin
            run_op(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);
        end

        // Reset mid-EXEC
        start_op(100, 7);
        tick();
        chk("midrst exec state", W'(state), W'(S_EXEC));
        repeat (10) tick();
        chk("midrst exec quotient", quotient, '0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midrst state", W'(state), W'(S_IDLE));
        chk("midrst quotient", quotient, '0);
        chk("midrst remainder", remainder, '0);
        chk("midrst dbz", W'(div_by_zero), '0);
        run_op("after midrst 100/7", 100, 7, 14, 2, 1'b0);

        // op_start held high through EXEC and DONE: no restart
        dividend = 1000;
        divisor  = 3;
        op_start = 1'b1;
        tick();
        wait_done(edges);
        chk("hold latency", W'(edges), W'(W + 2));
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (state != S_DONE) bad++;
        end
        chk("hold no restart", W'(bad), 0);
        chk("hold quotient", quotient, 333);
        chk("hold remainder", remainder, 1);
        // op_clear beats op_start: IDLE, and stays IDLE while both are high
        op_clear = 1'b1;
        tick();
        chk("clear+start state 1", W'(state), W'(S_IDLE));
        tick();
        chk("clear+start state 2", W'(state), W'(S_IDLE));
        op_clear = 1'b0;
        op_start = 1'b0;
        tick();
        chk("clear+start released", W'(state), W'(S_IDLE));

        // Abort at EXEC cycle 30, then a fresh operation
        start_op(ONES, 3);
        tick();
        repeat (30) tick();
        chk("abort exec state", W'(state), W'(S_EXEC));
        clear_and_check("abort");
        tick();
        chk("abort stays idle", W'(state), W'(S_IDLE));
        run_op("post-abort 50/5", 50, 5, 10, 0, 1'b0);

        // Randomized operations against the reference model
        for (int n = 0; n < 40; n++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: rb = {$urandom, $urandom};
                1: rb = W'($urandom_range(1, 1000));
                2: rb = {$urandom, $urandom} >> $urandom_range(1, W - 1);
                3: rb = W'(0) - W'($urandom_range(1, 50));
                default: rb = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 9));
            endcase
            if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(1, W - 1);
            model(ra, rb, mq, mr, mdz);
            run_op($sformatf("rand%0d", n), ra, rb, mq, mr, mdz);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
